// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipelined CPU.
package cpu_pkg;

    localparam int REG_W  = 4;
    localparam int ADDR_W = 16;

    typedef logic [REG_W-1:0]  reg_id_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // A destination of NOREG means the instruction writes no register.
    localparam reg_id_t NOREG      = 4'hF;
    localparam addr_t   INT_VECTOR = 16'h0000;

endpackage

// File: rtl/hazard_epc_reg.sv
// Exception PC register: captures the resume PC on every edge an interrupt
// request is high and emits a one-cycle "jump to vector" pulse.
module hazard_epc_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  capture,
    input  addr_t epc_next,
    output addr_t epc,
    output logic  int_taken
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc       <= '0;
            int_taken <= 1'b0;
        end else begin
            if (capture) begin
                epc <= epc_next;
            end
            int_taken <= capture;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/control unit: load-use stalls, JR redirects, branch-prediction
// checks and interrupt flushes for the IF/ID/EX pipeline registers.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    interception_i,
    input  logic    memtoreg_i,
    input  logic    memread_i,
    input  reg_id_t regsrc1_i,
    input  reg_id_t regsrc2_i,
    input  reg_id_t regdst_i,
    input  logic    isjump_i,
    output logic    jr_o,
    input  logic    ifbranch_i,
    input  logic    isbranch_i,
    input  logic    prediction_i,
    output logic    prewrong_o,
    output logic    precorrc_o,
    output logic    flush_if_o,
    output logic    flush_id_o,
    output logic    flush_ex_o,
    output logic    stall_o,
    output logic    isintzero_o,
    input  addr_t   epc_i,
    output addr_t   epc_o
);

    logic load_use;
    logic dst_valid;
    logic src_match;

    assign dst_valid = (regdst_i != NOREG);
    assign src_match = (regdst_i == regsrc1_i) || (regdst_i == regsrc2_i);
    assign load_use  = memread_i && memtoreg_i && dst_valid && src_match;

    // An interrupt or a mispredict discards whatever the stall or JR would
    // have preserved, so both lose priority to them.
    always_comb begin
        prewrong_o = isbranch_i && (ifbranch_i != prediction_i);
        precorrc_o = isbranch_i && (ifbranch_i == prediction_i);
        flush_if_o = prewrong_o || isjump_i || interception_i;
        flush_id_o = load_use || prewrong_o || interception_i;
        flush_ex_o = interception_i;
        stall_o    = load_use && !interception_i && !prewrong_o;
        jr_o       = isjump_i && !prewrong_o && !interception_i;
    end

    hazard_epc_reg u_epc_reg (
        .clk       (CLK),
        .rst_n     (RST),
        .capture   (interception_i),
        .epc_next  (epc_i),
        .epc       (epc_o),
        .int_taken (isintzero_o)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

    logic        CLK;
    logic        RST;
    logic        interception_i;
    logic        memtoreg_i;
    logic        memread_i;
    logic [3:0]  regsrc1_i;
    logic [3:0]  regsrc2_i;
    logic [3:0]  regdst_i;
    logic        isjump_i;
    logic        jr_o;
    logic        ifbranch_i;
    logic        isbranch_i;
    logic        prediction_i;
    logic        prewrong_o;
    logic        precorrc_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        flush_ex_o;
    logic        stall_o;
    logic        isintzero_o;
    logic [15:0] epc_i;
    logic [15:0] epc_o;

    int checks;
    int failures;

    hazard_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .interception_i (interception_i),
        .memtoreg_i     (memtoreg_i),
        .memread_i      (memread_i),
        .regsrc1_i      (regsrc1_i),
        .regsrc2_i      (regsrc2_i),
        .regdst_i       (regdst_i),
        .isjump_i       (isjump_i),
        .jr_o           (jr_o),
        .ifbranch_i     (ifbranch_i),
        .isbranch_i     (isbranch_i),
        .prediction_i   (prediction_i),
        .prewrong_o     (prewrong_o),
        .precorrc_o     (precorrc_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .flush_ex_o     (flush_ex_o),
        .stall_o        (stall_o),
        .isintzero_o    (isintzero_o),
        .epc_i          (epc_i),
        .epc_o          (epc_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Order: {jr, prewrong, precorrc, flush_if, flush_id, flush_ex, stall}
    task automatic checkComb(input string tag, input logic [6:0] expected);
        checkOutput(tag, {9'd0, jr_o, prewrong_o, precorrc_o, flush_if_o,
                          flush_id_o, flush_ex_o, stall_o}, {9'd0, expected});
    endtask

    task automatic applyStimulus(input logic mr, input logic m2r,
                                 input logic [3:0] s1, input logic [3:0] s2,
                                 input logic [3:0] dst, input logic jmp,
                                 input logic ib, input logic isb,
                                 input logic pred, input logic intr);
        memread_i      = mr;
        memtoreg_i     = m2r;
        regsrc1_i      = s1;
        regsrc2_i      = s2;
        regdst_i       = dst;
        isjump_i       = jmp;
        ifbranch_i     = ib;
        isbranch_i     = isb;
        prediction_i   = pred;
        interception_i = intr;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b0;
        epc_i    = 16'h0000;
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0);
        #11;
        checkOutput("reset_epc", epc_o, 16'h0000);
        checkOutput("reset_isintzero", {15'd0, isintzero_o}, 16'h0000);
        checkComb("idle_comb", 7'b0000000);

        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Interrupt EPC capture: the value present at the edge wins.
        epc_i = 16'hFFFF;
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 1);
        checkComb("int_flush", 7'b0001110);
        epc_i = 16'hFF00;
        @(posedge CLK);
        #1;
        checkOutput("int_epc", epc_o, 16'hFF00);
        checkOutput("int_isintzero", {15'd0, isintzero_o}, 16'h0001);
        @(negedge CLK);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        checkOutput("int_drop_isintzero", {15'd0, isintzero_o}, 16'h0000);
        checkOutput("int_drop_epc_hold", epc_o, 16'hFF00);

        // Load-use
        @(negedge CLK);
        applyStimulus(1, 1, 4'h3, 4'h0, 4'h3, 0, 0, 0, 0, 0);
        checkComb("lu_src1", 7'b0000101);
        applyStimulus(1, 1, 4'h0, 4'h3, 4'h3, 0, 0, 0, 0, 0);
        checkComb("lu_src2", 7'b0000101);
        applyStimulus(1, 1, 4'h4, 4'h5, 4'h3, 0, 0, 0, 0, 0);
        checkComb("lu_nomatch", 7'b0000000);
        applyStimulus(1, 1, 4'hF, 4'h5, 4'hF, 0, 0, 0, 0, 0);
        checkComb("lu_noreg", 7'b0000000);
        applyStimulus(1, 0, 4'h3, 4'h0, 4'h3, 0, 0, 0, 0, 0);
        checkComb("lu_no_memtoreg", 7'b0000000);

        // Branch prediction
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 1, 1, 0, 0);
        checkComb("br_wrong_taken", 7'b0101100);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 0, 1, 1, 0);
        checkComb("br_wrong_nottaken", 7'b0101100);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 1, 1, 1, 0);
        checkComb("br_correct", 7'b0010000);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 1, 0, 0, 0);
        checkComb("br_none", 7'b0000000);

        // JR and coinciding events
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0);
        checkComb("jr", 7'b1001000);
        applyStimulus(1, 1, 4'h3, 4'h0, 4'h3, 0, 0, 0, 0, 1);
        checkComb("lu_plus_int", 7'b0001110);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 1, 1, 1, 0, 0);
        checkComb("jr_plus_mispredict", 7'b0101100);
        applyStimulus(1, 1, 4'h3, 4'h0, 4'h3, 0, 1, 1, 0, 0);
        checkComb("lu_plus_mispredict", 7'b0101100);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 1);
        checkComb("jr_plus_int", 7'b0001110);

        // Level-held interrupt re-captures each edge, then async reset.
        epc_i = 16'h1234;
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 1);
        @(posedge CLK);
        #1;
        checkOutput("held_epc_1", epc_o, 16'h1234);
        @(negedge CLK);
        epc_i = 16'h5678;
        @(posedge CLK);
        #1;
        checkOutput("held_epc_2", epc_o, 16'h5678);
        checkOutput("held_isintzero", {15'd0, isintzero_o}, 16'h0001);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async_rst_epc", epc_o, 16'h0000);
        checkOutput("async_rst_isintzero", {15'd0, isintzero_o}, 16'h0000);
        checkComb("rst_comb_follow", 7'b0001110);

        // Release with the request still high: next edge captures again.
        @(negedge CLK);
        RST   = 1'b1;
        epc_i = 16'h0ABC;
        @(posedge CLK);
        #1;
        checkOutput("post_rst_epc", epc_o, 16'h0ABC);
        checkOutput("post_rst_isintzero", {15'd0, isintzero_o}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
